// File: rtl/wb_la_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_la_master_pkg
// Description : Shared widths, state encoding and counter width for the
//               wb_la_master Wishbone classic initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_la_master_pkg;

  // Wishbone bus widths
  localparam int C_WB_ADDR_W = 32;
  localparam int C_WB_DATA_W = 32;
  localparam int C_WB_SEL_W  = 4;

  // Width of the ack-timeout counter; holds any TIMEOUT_CYCLES up to 255
  localparam int C_TO_CNT_W  = 8;

  // Transfer state encoding (IDLE / BUS / RESP)
  typedef logic [1:0] state_t;
  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_BUS  = 2'd1;
  localparam logic [1:0] C_ST_RESP = 2'd2;

endpackage : wb_la_master_pkg
`default_nettype wire

// File: rtl/wb_la_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wb_la_timeout_cnt
// Description : Counts bus cycles spent waiting for ack. 'expired' is high
//               during the TIMEOUT_CYCLES-th counted cycle, so the owner can
//               abort on that same edge unless ack arrives with it.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_la_timeout_cnt
  import wb_la_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Count value seen during the final allowed wait cycle
  localparam logic [C_TO_CNT_W-1:0] C_LAST = C_TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [C_TO_CNT_W-1:0] r_count;

  // Wait-cycle counter: zeroed whenever the owner is not waiting on the bus
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + C_TO_CNT_W'(1);
    end
  end

  assign expired = (r_count == C_LAST);

endmodule : wb_la_timeout_cnt
`default_nettype wire

// File: rtl/wb_la_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_la_master
// Description : Single-outstanding Wishbone classic initiator. Accepts one
//               command, runs one cyc/stb cycle until ack, then holds the
//               response until it is taken.
//               Optional ack timeout enabled by macro WB_LA_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_la_master
  import wb_la_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  // command channel
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [C_WB_ADDR_W-1:0] cmd_addr,
  input  logic [C_WB_DATA_W-1:0] cmd_wdata,
  input  logic [C_WB_SEL_W-1:0]  cmd_sel,
  // response channel
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [C_WB_DATA_W-1:0] rsp_rdata,
  output logic                   rsp_err,
  // Wishbone initiator
  output logic                   o_wb_cyc,
  output logic                   o_wb_stb,
  output logic                   o_wb_we,
  output logic [C_WB_SEL_W-1:0]  o_wb_sel,
  output logic [C_WB_ADDR_W-1:0] o_wb_addr,
  output logic [C_WB_DATA_W-1:0] o_wb_data,
  input  logic                   i_wb_ack,
  input  logic [C_WB_DATA_W-1:0] i_wb_data
);

  state_t                 r_state;
  logic                   r_we;
  logic [C_WB_ADDR_W-1:0] r_addr;
  logic [C_WB_DATA_W-1:0] r_wdata;
  logic [C_WB_SEL_W-1:0]  r_sel;
  logic [C_WB_DATA_W-1:0] r_rdata;

  logic w_in_idle;
  logic w_in_bus;
  logic w_in_resp;
  logic w_accept;
  logic w_ack;
  logic w_expired;
  logic w_timeout;
  logic w_rsp_take;

  assign w_in_idle  = (r_state == C_ST_IDLE);
  assign w_in_bus   = (r_state == C_ST_BUS);
  assign w_in_resp  = (r_state == C_ST_RESP);
  // Reset forces cmd_ready low even though the state already reads IDLE
  assign w_accept   = w_in_idle && !wb_rst_i && cmd_valid;
  // Ack only counts while a cycle is on the bus; ack beats a same-cycle timeout
  assign w_ack      = w_in_bus && i_wb_ack;
  assign w_timeout  = w_in_bus && !i_wb_ack && w_expired;
  assign w_rsp_take = w_in_resp && rsp_ready;

`ifdef WB_LA_MASTER_TIMEOUT_EN
  logic r_err;

  wb_la_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (!w_in_bus),
    .enable (w_in_bus && !i_wb_ack),
    .expired(w_expired)
  );

  // Error flag: set by a timeout, cleared by ack completion or hand-off
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_err <= 1'b0;
    end else if (w_ack) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (w_rsp_take) begin
      r_err <= 1'b0;
    end
  end

  assign rsp_err = r_err;
`else
  // No timeout: the bus cycle waits for ack indefinitely
  assign w_expired = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // Transfer sequencing IDLE -> BUS -> RESP -> IDLE
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= C_ST_IDLE;
    end else begin
      case (r_state)
        C_ST_IDLE: if (w_accept)              r_state <= C_ST_BUS;
        C_ST_BUS:  if (w_ack || w_timeout)    r_state <= C_ST_RESP;
        C_ST_RESP: if (w_rsp_take)            r_state <= C_ST_IDLE;
        default:                              r_state <= C_ST_IDLE;
      endcase
    end
  end

  // Command capture; only loaded in IDLE so bus outputs stay frozen in BUS
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
    end else if (w_accept) begin
      r_we    <= cmd_we;
      r_addr  <= cmd_addr;
      r_wdata <= cmd_wdata;
      r_sel   <= cmd_sel;
    end
  end

  // Response data: read data captured at ack, zero for writes and timeouts
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rdata <= '0;
    end else if (w_ack) begin
      r_rdata <= r_we ? '0 : i_wb_data;
    end else if (w_timeout || w_rsp_take) begin
      r_rdata <= '0;
    end
  end

  assign cmd_ready = w_in_idle && !wb_rst_i;
  assign rsp_valid = w_in_resp;
  assign rsp_rdata = r_rdata;

  // Bus outputs are qualified by BUS so they read zero everywhere else
  assign o_wb_cyc  = w_in_bus;
  assign o_wb_stb  = w_in_bus;
  assign o_wb_we   = w_in_bus && r_we;
  assign o_wb_sel  = w_in_bus ? r_sel   : '0;
  assign o_wb_addr = w_in_bus ? r_addr  : '0;
  assign o_wb_data = w_in_bus ? r_wdata : '0;

endmodule : wb_la_master
`default_nettype wire
